// File: rtl/mult16_seq_if.sv
// ---------------------------------------------------------------------------
// mult16_seq_if
// Operand/product handshake bundle for the sequential multiplier.
//   in_valid / in_ready   : operand pair handshake (IN1, IN2)
//   out_valid / out_ready : product handshake (P)
// Modports:
//   master : the feeder/collector side (drives operands, accepts products)
//   slave  : the multiplier side
// Parameters must match the multiplier instance (outwidth == 2*width).
// ---------------------------------------------------------------------------
interface mult16_seq_if #(
   parameter int width    = 16,
   parameter int outwidth = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [width-1:0]    IN1;
   logic [width-1:0]    IN2;
   logic                out_valid;
   logic                out_ready;
   logic [outwidth-1:0] P;

   modport master (
      output in_valid, IN1, IN2, out_ready,
      input  in_ready, out_valid, P
   );

   modport slave (
      input  in_valid, IN1, IN2, out_ready,
      output in_ready, out_valid, P
   );
endinterface

// File: rtl/mult16_seq.sv
// ---------------------------------------------------------------------------
// mult16_seq
// Unsigned width x width shift-add multiplier, one partial product per cycle.
// Fixed latency: an operand pair accepted at edge k yields P valid after edge
// k+width, independent of the operand values.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : mult16_seq_if.slave (in_valid/in_ready/IN1/IN2,
//            out_valid/out_ready/P)
// ---------------------------------------------------------------------------
module mult16_seq #(
   parameter int width    = 16,
   parameter int outwidth = 32   // must be 2*width
) (
   input  logic         clk,
   input  logic         rst_n,
   mult16_seq_if.slave  bus
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [width-1:0]    mcand;
   logic [outwidth-1:0] acc;
   logic [CW-1:0]       count;
   logic [outwidth-1:0] p_q;

   logic [width:0]      sum;
   logic [outwidth-1:0] acc_next;

   // acc holds {partial product high half, unconsumed multiplier bits}.
   // The add is width+1 bits wide so its carry lands in the top bit of
   // acc after the right shift; the high half can never overflow.
   always_comb begin
      sum = {1'b0, acc[outwidth-1:width]};
      if (acc[0])
         sum = {1'b0, acc[outwidth-1:width]} + {1'b0, mcand};
      acc_next = {sum, acc[width-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         mcand <= '0;
         acc   <= '0;
         count <= '0;
         p_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // in_ready is just (IDLE && rst_n), and rst_n is high here
               if (bus.in_valid) begin
                  mcand <= bus.IN1;
                  acc   <= {{(outwidth-width){1'b0}}, bus.IN2};
                  count <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               acc   <= acc_next;
               count <= count + CW'(1);
               if (count == LAST) begin
                  p_q   <= acc_next;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               // P (p_q) is left untouched so it holds after the handshake
               if (bus.out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE) && rst_n;
   assign bus.out_valid = (state == S_DONE);
   assign bus.P         = p_q;

endmodule

// File: tb/tb_mult16_seq.sv
module tb_mult16_seq;
   localparam int W  = 16;
   localparam int OW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mult16_seq_if #(.width(W), .outwidth(OW)) bus ();

   mult16_seq #(.width(W), .outwidth(OW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each accepted pair becomes an entry holding its exact product and the
   // edge number after which it must be presented. The block is busy from
   // accept until the product is taken.
   typedef struct {
      logic [OW-1:0] prod;
      int            due;
   } exp_t;

   exp_t          q[$];
   bit            busy = 0;
   bit            on = 0;
   logic [OW-1:0] last_p = '0;
   int            cyc = 0;
   bit            stream = 0;
   int            last_hs = -1;
   int            dut_outs = 0;

   always @(posedge clk) begin
      bit ov_pre, ir_pre;
      ov_pre = on && (q.size() > 0) && (q[0].due <= cyc);
      ir_pre = rst_n && !busy;
      if (bus.out_valid && bus.out_ready) dut_outs++;
      if (!rst_n) begin
         q.delete();
         busy   = 0;
         last_p = '0;
         on     = 1;
      end else if (on) begin
         if (ov_pre && bus.out_ready) begin
            last_p = q[0].prod;
            void'(q.pop_front());
            busy = 0;
            if (stream && last_hs >= 0) chk("stream_spacing", cyc + 1 - last_hs, W + 2);
            last_hs = cyc + 1;
         end
         if (ir_pre && bus.in_valid) begin
            q.push_back('{prod: OW'(bus.IN1) * OW'(bus.IN2), due: cyc + 1 + W});
            busy = 1;
         end
      end
      cyc++;
   end

   // One compare process: every cycle after the first reset edge
   always @(negedge clk) begin
      if (on) begin
         bit            e_ov;
         logic [OW-1:0] e_p;
         e_ov = (q.size() > 0) && (q[0].due <= cyc);
         e_p  = e_ov ? q[0].prod : last_p;
         chk("out_valid", bus.out_valid, e_ov);
         chk("P", bus.P, e_p);
         chk("in_ready", bus.in_ready, rst_n && !busy);
      end
   end

   // ---------------- stimulus helpers ----------------
   // All drives happen 2 time units after a rising edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep,
                       output int acc_cyc);
      int   n;
      logic ok;
      bus.IN1 = a;
      bus.IN2 = b;
      bus.in_valid = 1'b1;
      n = 0;
      do begin
         ok = bus.in_ready;
         @(posedge clk); #2;
         n++;
      end while (!ok && n < 200);
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout actual=%0d cycles required=<200", n);
      end
      acc_cyc = cyc;
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input logic [OW-1:0] exp_p, input int acc_cyc);
      int n;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      chk({name, "_P"}, bus.P, exp_p);
      chk({name, "_latency"}, cyc - acc_cyc, W);
   endtask

   task automatic next_cycle();
      @(posedge clk); #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ac, c0, outs0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.IN1       = '0;
      bus.IN2       = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_P", bus.P, 0);
      chk("reset_in_ready", bus.in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_reset", bus.in_ready, 1);
      #1;

      // basic product
      chk("basic_in_ready_before", bus.in_ready, 1);
      send(16'd3, 16'd5, 0, ac);
      wait_out("basic", 32'd15, ac);
      next_cycle();
      chk("basic_in_ready_after", bus.in_ready, 1);
      chk("basic_out_valid_cleared", bus.out_valid, 0);
      chk("basic_P_held", bus.P, 32'd15);

      // corner operands
      send(16'hFFFF, 16'hFFFF, 0, ac); wait_out("max", 32'hFFFE0001, ac); next_cycle();
      send(16'd0, 16'd40000, 0, ac);   wait_out("zero", 32'd0, ac);       next_cycle();
      send(16'd1, 16'hFFFF, 0, ac);    wait_out("one", 32'd65535, ac);    next_cycle();

      // backpressure with a pending pair
      bus.out_ready = 1'b0;
      send(16'd1234, 16'd567, 0, ac);
      bus.IN1 = 16'd11; bus.IN2 = 16'd13; bus.in_valid = 1'b1;
      wait_out("bp", 32'd699678, ac);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_P", bus.P, 32'd699678);
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
         next_cycle();
      end
      c0 = cyc;
      bus.out_ready = 1'b1;
      send(16'd11, 16'd13, 0, ac);
      chk("bp_pending_accept_edge", ac, c0 + 2);
      wait_out("bp_next", 32'd143, ac);
      next_cycle();

      // operand isolation
      send(16'd100, 16'd200, 0, ac);
      bus.IN1 = 16'hFFFF; bus.IN2 = 16'hFFFF; bus.in_valid = 1'b1;
      next_cycle();
      chk("iso_in_ready_run", bus.in_ready, 0);
      wait_out("iso", 32'd20000, ac);
      bus.in_valid = 1'b0;
      next_cycle();
      repeat (20) next_cycle();
      chk("iso_single_product", bus.out_valid, 0);

      // reset mid-run
      send(16'd7, 16'd9, 0, ac);
      repeat (6) next_cycle();
      rst_n = 1'b0;
      next_cycle();
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_P", bus.P, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      rst_n = 1'b1;
      repeat (20) next_cycle();
      chk("midrst_no_product", bus.out_valid, 0);
      send(16'd2, 16'd3, 0, ac);
      wait_out("after_rst", 32'd6, ac);
      next_cycle();

      // back-to-back random stream
      outs0   = dut_outs;
      stream  = 1;
      last_hs = -1;
      for (int i = 0; i < 1000; i++) begin
         send(16'($urandom), 16'($urandom), 1, ac);
      end
      bus.in_valid = 1'b0;
      repeat (W + 4) next_cycle();
      chk("stream_count", dut_outs - outs0, 1000);
      stream = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
